// File: rtl/exec_alu_stage.sv
// -----------------------------------------------------------------------------
// exec_alu_stage
//
// Execute stage sitting directly behind the register file. Takes the two read
// operands (Bus_A / Bus_B, or an immediate in place of B), computes a result and
// drives the register-file write port (Bus_W, RW, reg_write).
//
// Single-cycle ops (ADD..SLTU) complete with latency 1 and may be issued every
// cycle. MUL runs a fixed-length shift-add multiplier under a three-state FSM
// (IDLE -> MUL -> DONE -> IDLE); the stage is busy for WIDTH+1 cycles and the
// write pulse appears WIDTH+2 cycles after the accepting edge counted as
// latency (i.e. on the same cycle in_ready returns high).
//
// Ports
//   clk        in   clock, rising-edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operation presented this cycle
//   in_ready   out  stage can accept (high only in IDLE)
//   op         in   4-bit opcode (0..10 legal, 11..15 illegal)
//   Bus_A      in   operand A
//   Bus_B      in   operand B
//   imm        in   immediate operand
//   use_imm    in   select imm instead of Bus_B as operand B
//   rd         in   destination register
//   Bus_W      out  result (write data)
//   RW         out  destination (write address)
//   reg_write  out  one-cycle write-enable pulse; never asserted for rd == 0
//   zero       out  Bus_W == 0, registered together with Bus_W
//   illegal    out  one-cycle pulse for an unsupported opcode
// -----------------------------------------------------------------------------
module exec_alu_stage #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] Bus_A,
    input  logic [WIDTH-1:0] Bus_B,
    input  logic [WIDTH-1:0] imm,
    input  logic             use_imm,
    input  logic [AW-1:0]    rd,
    output logic [WIDTH-1:0] Bus_W,
    output logic [AW-1:0]    RW,
    output logic             reg_write,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state, state_nxt;

    // Multiplier working registers
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [AW-1:0]    mul_rd;

    // Single-cycle datapath
    logic [WIDTH-1:0] opnd_b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_legal;
    logic             accept;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign opnd_b   = use_imm ? imm : Bus_B;
    assign shamt    = opnd_b[SHW-1:0];

    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (op)
            OP_ADD:  alu_res = Bus_A + opnd_b;
            OP_SUB:  alu_res = Bus_A - opnd_b;
            OP_AND:  alu_res = Bus_A & opnd_b;
            OP_OR:   alu_res = Bus_A | opnd_b;
            OP_XOR:  alu_res = Bus_A ^ opnd_b;
            OP_SLL:  alu_res = Bus_A << shamt;
            OP_SRL:  alu_res = Bus_A >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(Bus_A) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(Bus_A) < $signed(opnd_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (Bus_A < opnd_b)};
            OP_MUL:  alu_res = '0;  // handled by the FSM
            default: alu_legal = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && op == OP_MUL) state_nxt = S_MUL;
            S_MUL:  if (count == CW'(WIDTH - 1)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Bus_W     <= '0;
            RW        <= '0;
            reg_write <= 1'b0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            mul_rd    <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle and are raised only on
            // the cycle an op completes; everything else holds its last value.
            reg_write <= 1'b0;
            illegal   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mcand  <= Bus_A;
                            mplier <= opnd_b;
                            acc    <= '0;
                            count  <= '0;
                            mul_rd <= rd;
                        end else if (alu_legal) begin
                            Bus_W     <= alu_res;
                            RW        <= rd;
                            zero      <= (alu_res == '0);
                            reg_write <= (rd != '0);
                        end else begin
                            Bus_W   <= '0;
                            RW      <= rd;
                            zero    <= 1'b1;
                            illegal <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    // Fixed WIDTH iterations; no early exit on a zero multiplier.
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                end

                S_DONE: begin
                    Bus_W     <= acc;
                    RW        <= mul_rd;
                    zero      <= (acc == '0);
                    reg_write <= (mul_rd != '0);
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_exec_alu_stage
//
// Directed vectors with hand-computed results. The stimulus process pushes the
// expected write-back (data, address, zero, illegal flag, due cycle) into a
// queue; a monitor on the falling edge pops and compares whenever the DUT
// raises reg_write or illegal. A pulse with nothing expected is an error.
// -----------------------------------------------------------------------------
module tb_exec_alu_stage;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] Bus_A;
    logic [WIDTH-1:0] Bus_B;
    logic [WIDTH-1:0] imm;
    logic             use_imm;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] Bus_W;
    logic [AW-1:0]    RW;
    logic             reg_write;
    logic             zero;
    logic             illegal;

    exec_alu_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .Bus_A     (Bus_A),
        .Bus_B     (Bus_B),
        .imm       (imm),
        .use_imm   (use_imm),
        .rd        (rd),
        .Bus_W     (Bus_W),
        .RW        (RW),
        .reg_write (reg_write),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] w;
        logic [AW-1:0]    rw;
        logic             z;
        logic             ill;
        int               due;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && (reg_write || illegal)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {62'd0, reg_write, illegal}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("Bus_W",     64'(Bus_W),     64'(e.w));
                check("RW",        64'(RW),        64'(e.rw));
                check("zero",      64'(zero),      64'(e.z));
                check("illegal",   64'(illegal),   64'(e.ill));
                check("reg_write", 64'(reg_write), 64'(!e.ill));
                check("latency",   64'(cyc),       64'(e.due));
            end
        end
    end

    // Present one op, hold in_valid until accepted, push the expected result.
    // 'waited' returns the number of cycles in_ready was seen low.
    task automatic send(input logic [3:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] im,
                        input logic ui, input logic [AW-1:0] r,
                        input logic [WIDTH-1:0] ew, input bit push,
                        output int waited);
        int   lat;
        bit   ill;
        exp_t e;
        @(negedge clk);
        op = o; Bus_A = a; Bus_B = b; imm = im; use_imm = ui; rd = r;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 64'(waited), 64'd0);
        ill = (o > 4'd10);
        lat = (o == 4'd10) ? WIDTH + 2 : 1;
        if (push && (r != '0 || ill)) begin
            e.w   = ill ? '0 : ew;
            e.rw  = r;
            e.z   = ill ? 1'b1 : (ew == '0);
            e.ill = ill;
            e.due = cyc + lat;  // accepting edge is cyc+1; visible lat-1 edges later
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; Bus_A = '0; Bus_B = '0;
        imm = '0; use_imm = 1'b0; rd = '0;
        #23 rst_n = 1'b1;
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_reg_write", 64'(reg_write), 64'd0);
        check("rst_zero",      64'(zero),      64'd1);

        // ADD, then back-to-back single-cycle ops
        send(4'd0, 32'h5, 32'h7, 32'h0, 1'b0, 5'd3, 32'h0000_000C, 1'b1, w);
        send(4'd1, 32'h0, 32'h1, 32'h0, 1'b0, 5'd4, 32'hFFFF_FFFF, 1'b1, w);
        send(4'd8, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd5, 32'h1, 1'b1, w);
        send(4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd6, 32'h0, 1'b1, w);
        send(4'd7, 32'h8000_0000, 32'h1, 32'h4, 1'b1, 5'd8, 32'hF800_0000, 1'b1, w);
        send(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b0, 5'd9, 32'hF000_F000, 1'b1, w);
        send(4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 1'b0, 5'd10, 32'hF0F0_0F0F, 1'b1, w);
        send(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0, 1'b0, 5'd11, 32'h5555_5555, 1'b1, w);
        send(4'd5, 32'h1, 32'h0, 32'h1F, 1'b1, 5'd12, 32'h8000_0000, 1'b1, w);
        send(4'd6, 32'h8000_0000, 32'h0000_0024, 32'h0, 1'b0, 5'd13, 32'h0800_0000, 1'b1, w);
        send(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd14, 32'h0, 1'b1, w);

        // R0: data and address update, no write pulse
        send(4'd0, 32'h2, 32'h3, 32'h0, 1'b0, 5'd0, 32'h5, 1'b1, w);
        check("r0_Bus_W",     64'(Bus_W),     64'd5);
        check("r0_RW",        64'(RW),        64'd0);
        check("r0_zero",      64'(zero),      64'd0);
        check("r0_reg_write", 64'(reg_write), 64'd0);

        // Illegal opcode
        send(4'd12, 32'h1234, 32'h1, 32'h0, 1'b0, 5'd15, 32'h0, 1'b1, w);

        // MUL with a following ADD held valid while busy
        send(4'd10, 32'h0001_0003, 32'h0000_0100, 32'h0, 1'b0, 5'd7, 32'h0100_0300, 1'b1, w);
        check("mul_in_ready_now", 64'(in_ready), 64'd0);
        send(4'd0, 32'h1, 32'h1, 32'h0, 1'b0, 5'd2, 32'h2, 1'b1, w);
        check("mul_busy_cycles", 64'(w), 64'(WIDTH + 1));

        // MUL low word with a negative operand
        send(4'd10, 32'hFFFF_FFFF, 32'h3, 32'h0, 1'b0, 5'd17, 32'hFFFF_FFFD, 1'b1, w);
        wait_cycles(WIDTH + 3);

        // Async reset mid-cycle, no clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_Bus_W",     64'(Bus_W),     64'd0);
        check("async_RW",        64'(RW),        64'd0);
        check("async_zero",      64'(zero),      64'd1);
        check("async_reg_write", 64'(reg_write), 64'd0);
        #1 rst_n = 1'b1;

        // Abort MUL at iteration 10: no write pulse, then a normal ADD
        send(4'd10, 32'h7, 32'h9, 32'h0, 1'b0, 5'd20, 32'h0, 1'b0, w);
        wait_cycles(9);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_Bus_W",    64'(Bus_W),    64'd0);
        wait_cycles(WIDTH + 4);
        send(4'd0, 32'h10, 32'h20, 32'h0, 1'b0, 5'd21, 32'h30, 1'b1, w);
        check("abort_add_wait", 64'(w), 64'd0);

        wait_cycles(4);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_alu_stage.md
Name: exec_alu_stage

Overview:
- Execute stage directly downstream of RegFile: consumes Bus_A/Bus_B read operands, computes a result and drives the write-back triple (Bus_W, RW, reg_write) back into RegFile's write port.
- Single-cycle ALU ops plus a multi-cycle shift-add multiplier under a small FSM.
- Valid/ready handshake on the input side; one-cycle write pulse on the output side.

Parameters:
- WIDTH, 32, datapath width; equals RegFile word width.
- AW, 5, register address width; equals RegFile RA/RB/RW width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  stage can accept; high only in IDLE.
- op  in  4  opcode; see Behaviour.
- Bus_A  in  WIDTH  operand A from RegFile.
- Bus_B  in  WIDTH  operand B from RegFile.
- imm  in  WIDTH  immediate operand.
- use_imm  in  1  when 1, operand B = imm instead of Bus_B.
- rd  in  AW  destination register.
- Bus_W  out  WIDTH  result to RegFile write data.
- RW  out  AW  destination to RegFile write address.
- reg_write  out  1  one-cycle write-enable pulse to RegFile.
- zero  out  1  registered with Bus_W: result == 0.
- illegal  out  1  one-cycle pulse for an unsupported opcode.

Behaviour:
- Reset: async on rst_n low. State=IDLE; Bus_W=0, RW=0, reg_write=0, zero=1, illegal=0; multiplier registers cleared. in_ready=1 once rst_n is high.
- Accept: in_valid && in_ready at a rising edge. A, B (or imm), op and rd are latched. Inputs are ignored when in_ready=0.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: modulo 2^WIDTH; no carry out.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = B[4:0].
  - 8 SLT (signed), 9 SLTU (unsigned): result 1 or 0.
  - 10 MUL: low WIDTH bits of the unsigned product; the low word is identical for signed operands.
  - 11-15 illegal.
- Single-cycle ops: the result is registered on the accepting edge. Bus_W, RW=rd, zero and reg_write=1 are visible in the following cycle; latency 1. State stays IDLE, so back-to-back accepts are allowed every cycle.
- reg_write is a one-cycle pulse. It is 0 in every cycle without a completed op.
- RW==0 suppression: if rd==0, reg_write stays 0 (R0 is never written), but Bus_W, RW and zero still update.
- Illegal op: illegal=1 and reg_write=0 for one cycle; Bus_W=0, zero=1. State stays IDLE.
- MUL FSM, states IDLE -> MUL -> DONE -> IDLE:
  - Accept: latch multiplicand=A, multiplier=B, acc=0, count=0. Go to MUL; in_ready drops to 0 in the next cycle.
  - MUL, each cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. After WIDTH iterations go to DONE.
  - DONE: register acc to Bus_W; reg_write pulses per the rd rule in the next cycle. Return to IDLE.
  - Total latency from accepting edge to reg_write high = WIDTH+2 cycles (34 at default). in_ready is 0 for WIDTH+1 cycles.
- Early termination is not allowed; latency is fixed.
- Outputs hold their last value between pulses; only reg_write and illegal return to 0.
- rst_n asserted mid-MUL: the FSM aborts immediately to IDLE and no write pulse occurs.
- in_valid held high during MUL: not accepted. It is accepted on the first edge after return to IDLE.
- Hazards and forwarding are handled upstream; this stage does no operand bypass.

Test Plan:
- Reset: rst_n low mid-cycle (no clock edge) -> outputs reset immediately; after release, in_ready=1 and reg_write=0.
- ADD: A=0x0000_0005, B=0x0000_0007, rd=3 -> next cycle Bus_W=0x0C, RW=3, reg_write=1 for exactly one cycle, zero=0.
- Wrap and compare: SUB with A=0, B=1 -> Bus_W=0xFFFF_FFFF. SLT with A=0xFFFF_FFFF, B=1 -> 1. SLTU on the same operands -> 0. SRA with A=0x8000_0000, imm=4, use_imm=1 -> 0xF800_0000.
- R0 and illegal: ADD with rd=0 -> Bus_W updates, reg_write stays 0. op=12 -> illegal pulses one cycle, reg_write=0.
- MUL: A=0x0001_0003, B=0x0000_0100, rd=7 with in_valid held high:
  - in_ready=0 for 33 cycles; reg_write rises 34 cycles after accept with Bus_W=0x0100_0300.
  - A following ADD is accepted only after return to IDLE.
- Abort: MUL accepted, then rst_n pulsed low at iteration 10 -> no reg_write; state IDLE; the next ADD completes normally with 1-cycle latency.
